// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   - sa_state_t   : controller state (IDLE, RUN, DONE)
//   - SA_ENC_*     : raw state encodings, used by benches for state checks
//   - sa_cnt_width : width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam logic [1:0] SA_ENC_IDLE = 2'd0;
  localparam logic [1:0] SA_ENC_RUN  = 2'd1;
  localparam logic [1:0] SA_ENC_DONE = 2'd2;

  // One spare bit so the counter can reach WIDTH without wrapping.
  function automatic int sa_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Operand/result handshake bundle for serial_adder.
//   Input side : in_valid, in_ready, a, b, cin
//   Output side: out_valid, out_ready, sum, cout, overflow
//   master = operand producer / result consumer, slave = the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder cell.
//   Ports: a, b, cin (inputs), sum, cout (outputs).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: one full_adder cell sequenced over WIDTH
//   clocks, LSB first, with valid/ready handshakes on both sides.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - serial_adder_if.slave (operands in, sum/cout/overflow out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int            CW       = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
      $error("serial_adder: WIDTH must be in 1..64");
    end
  endgenerate

  sa_state_t        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_msb;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_sum;
  logic             w_fa_cout;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Controller FSM and serial datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // r_carry here is the carry into the MSB, needed for overflow.
            r_c_msb <= r_carry;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags depend on the state register only.
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_carry;
  assign bus.overflow  = r_c_msb ^ r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder at WIDTH=8, 4 and 1.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_inputs;
    if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = 4'h0;  if4.b = 4'h0;  if4.cin = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = 1'b0;  if1.b = 1'b0;  if1.cin = 1'b0; if1.out_ready = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c, output bit ok);
    int g;
    g = 0;
    while (!if8.in_ready && g < 50) begin @(negedge clk); g++; end
    ok = if8.in_ready;
    if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
  endtask

  task automatic start1(input logic a, input logic b, input logic c, output bit ok);
    int g;
    g = 0;
    while (!if1.in_ready && g < 50) begin @(negedge clk); g++; end
    ok = if1.in_ready;
    if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    init_inputs();
    repeat (2) @(negedge clk);
    n_tests++; if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", if8.in_ready); end
    n_tests++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if8.out_valid); end
    n_tests++; if (if8.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", if8.sum); end
    n_tests++; if (if8.cout !== 1'b0 || if8.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got cout=%b ovf=%b expected 0/0", if8.cout, if8.overflow); end
    n_tests++; if (u_dut8.r_state !== SA_ENC_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", u_dut8.r_state, SA_ENC_IDLE); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got rdy=%b vld=%b expected 1/0", if8.in_ready, if8.out_valid); end
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    if8.out_ready = 1'b1;
    start8(8'h35, 8'h4A, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got in_ready=0 expected 1"); end
    cyc = 0;
    while (!if8.out_valid && cyc < 30) begin @(negedge clk); cyc++; end
    n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL basic_latency: got %0d cycles expected 8", cyc); end
    n_tests++; if (if8.sum !== 8'h7F) begin n_fail++; $display("FAIL basic_sum: got %h expected 7f", if8.sum); end
    n_tests++; if (if8.cout !== 1'b0 || if8.overflow !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got cout=%b ovf=%b expected 0/0", if8.cout, if8.overflow); end
    @(negedge clk);
    n_tests++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_one_cycle: got vld=%b rdy=%b expected 0/1", if8.out_valid, if8.in_ready); end
  endtask

  task automatic test_carry;
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic [7:0] es[3];
    logic       ec[3];
    logic       eo[3];
    bit ok;
    int cyc;
    ta[0] = 8'hFF; tb[0] = 8'h01; es[0] = 8'h00; ec[0] = 1'b1; eo[0] = 1'b0;
    ta[1] = 8'h7F; tb[1] = 8'h01; es[1] = 8'h80; ec[1] = 1'b0; eo[1] = 1'b1;
    ta[2] = 8'h80; tb[2] = 8'hFF; es[2] = 8'h7F; ec[2] = 1'b1; eo[2] = 1'b1;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start8(ta[i], tb[i], 1'b0, ok);
      cyc = 0;
      while (!if8.out_valid && cyc < 30) begin @(negedge clk); cyc++; end
      n_tests++; if (!ok || cyc != 8) begin n_fail++; $display("FAIL carry_latency[%0d]: got ok=%0d cyc=%0d expected 1/8", i, ok, cyc); end
      n_tests++; if (if8.sum !== es[i]) begin n_fail++; $display("FAIL carry_sum[%0d]: got %h expected %h", i, if8.sum, es[i]); end
      n_tests++; if (if8.cout !== ec[i]) begin n_fail++; $display("FAIL carry_cout[%0d]: got %b expected %b", i, if8.cout, ec[i]); end
      n_tests++; if (if8.overflow !== eo[i]) begin n_fail++; $display("FAIL carry_ovf[%0d]: got %b expected %b", i, if8.overflow, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int cyc;
    if8.out_ready = 1'b0;
    start8(8'hFF, 8'hFF, 1'b1, ok);
    // Competing operands presented through RUN and DONE must be ignored.
    if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0; if8.in_valid = 1'b1;
    cyc = 0;
    while (!if8.out_valid && cyc < 30) begin @(negedge clk); cyc++; end
    n_tests++; if (!ok || cyc != 8) begin n_fail++; $display("FAIL bp_latency: got ok=%0d cyc=%0d expected 1/8", ok, cyc); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_hs[%0d]: got vld=%b rdy=%b expected 1/0", k, if8.out_valid, if8.in_ready); end
      n_tests++; if (if8.sum !== 8'hFF || if8.cout !== 1'b1 || if8.overflow !== 1'b0) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got sum=%h cout=%b ovf=%b expected ff/1/0", k, if8.sum, if8.cout, if8.overflow); end
      @(negedge clk);
    end
    if8.out_ready = 1'b1;
    if8.in_valid  = 1'b0;
    @(negedge clk);
    n_tests++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b expected 0/1", if8.out_valid, if8.in_ready); end
    n_tests++; if (u_dut8.r_state !== SA_ENC_IDLE) begin n_fail++; $display("FAIL bp_idle_state: got %0d expected %0d", u_dut8.r_state, SA_ENC_IDLE); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int cyc;
    int spurious;
    if8.out_ready = 1'b1;
    start8(8'h0F, 8'h01, 1'b0, ok);
    repeat (4) @(negedge clk);
    n_tests++; if (!ok || u_dut8.r_state !== SA_ENC_RUN) begin n_fail++; $display("FAIL rst_in_run: got ok=%0d state=%0d expected 1/%0d", ok, u_dut8.r_state, SA_ENC_RUN); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_immediate: got vld=%b rdy=%b expected 0/1", if8.out_valid, if8.in_ready); end
    n_tests++; if (if8.sum !== 8'h00 || u_dut8.r_state !== SA_ENC_IDLE) begin n_fail++; $display("FAIL rst_clear: got sum=%h state=%0d expected 00/%0d", if8.sum, u_dut8.r_state, SA_ENC_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      if (if8.out_valid) spurious++;
      @(negedge clk);
    end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL rst_no_result: got %0d out_valid cycles expected 0", spurious); end
    start8(8'h01, 8'h02, 1'b0, ok);
    cyc = 0;
    while (!if8.out_valid && cyc < 30) begin @(negedge clk); cyc++; end
    n_tests++; if (!ok || cyc != 8) begin n_fail++; $display("FAIL rst_next_latency: got ok=%0d cyc=%0d expected 1/8", ok, cyc); end
    n_tests++; if (if8.sum !== 8'h03 || if8.cout !== 1'b0 || if8.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_next_result: got sum=%h cout=%b ovf=%b expected 03/0/0", if8.sum, if8.cout, if8.overflow); end
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_sweep4;
    logic [5:0] exp_q[$];
    int  received;
    int  bad;
    bit  prod_ok;
    received = 0;
    bad      = 0;
    prod_ok  = 1'b1;
    fork
      begin : producer
        for (int i = 0; i < 512; i++) begin
          logic [3:0] ta;
          logic [3:0] tb;
          logic       tc;
          logic [4:0] full;
          logic       ov;
          int         g;
          ta = 4'(i);
          tb = 4'(i >> 4);
          tc = 1'(i >> 8);
          g  = 0;
          if4.a = ta; if4.b = tb; if4.cin = tc; if4.in_valid = 1'b1;
          while (!if4.in_ready && g < 100) begin @(negedge clk); g++; end
          if (!if4.in_ready) prod_ok = 1'b0;
          full = 5'(ta) + 5'(tb) + 5'(tc);
          ov   = (ta[3] == tb[3]) && (full[3] != ta[3]);
          exp_q.push_back({ov, full});
          @(negedge clk);
        end
        if4.in_valid = 1'b0;
      end
      begin : consumer
        for (int cyc = 0; cyc < 20000 && received < 512; cyc++) begin
          logic [5:0] got;
          if4.out_ready = 1'($urandom_range(0, 1));
          if (if4.out_valid && if4.out_ready) begin
            got = {if4.overflow, if4.cout, if4.sum};
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL sweep4_extra: got result %h with no pending operation", got);
            end else begin
              if (got !== exp_q[0]) begin
                n_fail++;
                bad++;
                $display("FAIL sweep4_result[%0d]: got {ovf,cout,sum}=%h expected %h", received, got, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            received++;
          end
          @(negedge clk);
        end
      end
    join
    if4.out_ready = 1'b0;
    n_tests++; if (!prod_ok) begin n_fail++; $display("FAIL sweep4_accept_timeout: got in_ready stuck low expected accept"); end
    n_tests++; if (received != 512) begin n_fail++; $display("FAIL sweep4_count: got %0d transfers expected 512", received); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sweep4_pending: got %0d unreturned ops expected 0", exp_q.size()); end
  endtask

  task automatic test_width1;
    bit ok;
    int cyc;
    if1.out_ready = 1'b1;
    // LSBs of 8'h35 + 8'h4A: 1 + 0 + 0.
    start1(1'b1, 1'b0, 1'b0, ok);
    cyc = 0;
    while (!if1.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    n_tests++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL w1_latency: got ok=%0d cyc=%0d expected 1/1", ok, cyc); end
    n_tests++; if (if1.sum !== 1'b1 || if1.cout !== 1'b0 || if1.overflow !== 1'b0) begin n_fail++; $display("FAIL w1_basic: got sum=%b cout=%b ovf=%b expected 1/0/0", if1.sum, if1.cout, if1.overflow); end
    @(negedge clk);
    n_tests++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL w1_one_cycle: got vld=%b rdy=%b expected 0/1", if1.out_valid, if1.in_ready); end
    // Carry into the only bit is cin (0), carry out is 1 -> overflow.
    start1(1'b1, 1'b1, 1'b0, ok);
    cyc = 0;
    while (!if1.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    n_tests++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL w1_latency2: got ok=%0d cyc=%0d expected 1/1", ok, cyc); end
    n_tests++; if (if1.sum !== 1'b0 || if1.cout !== 1'b1 || if1.overflow !== 1'b1) begin n_fail++; $display("FAIL w1_ovf: got sum=%b cout=%b ovf=%b expected 0/1/1", if1.sum, if1.cout, if1.overflow); end
    @(negedge clk);
    // cin=1 makes carry-in equal carry-out -> no overflow.
    start1(1'b1, 1'b1, 1'b1, ok);
    cyc = 0;
    while (!if1.out_valid && cyc < 10) begin @(negedge clk); cyc++; end
    n_tests++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL w1_latency3: got ok=%0d cyc=%0d expected 1/1", ok, cyc); end
    n_tests++; if (if1.sum !== 1'b1 || if1.cout !== 1'b1 || if1.overflow !== 1'b0) begin n_fail++; $display("FAIL w1_cin: got sum=%b cout=%b ovf=%b expected 1/1/0", if1.sum, if1.cout, if1.overflow); end
    @(negedge clk);
    if1.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_async_reset();
    test_sweep4();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder controller that sequences the single-bit `full_adder` cell over WIDTH cycles, one bit per clock, LSB first. It accepts an operand pair through a valid/ready input handshake and holds the result until the consumer takes it through a valid/ready output handshake. It is the area-minimal adder option in the arithmetic library, intended for slow control paths where one `full_adder` instance replaces a WIDTH-bit ripple adder.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 1..64.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair `a`, `b`, `cin` valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: first operand.
- `b` in WIDTH: second operand.
- `cin` in 1: carry in.
- `out_valid` out 1: `sum`, `cout` and `overflow` valid.
- `out_ready` in 1: consumer accepts the result.
- `sum` out WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout` out 1: unsigned carry out.
- `overflow` out 1: two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states:
  - IDLE: `in_ready`=1. Transfer on `in_valid && in_ready`: load the A/B shift registers, set carry reg = `cin`, set bit counter = 0, go to RUN.
  - RUN: `full_adder` inputs are A[0], B[0] and the carry reg. On each edge:
    - the sum bit shifts into the sum register MSB (the register shifts right);
    - A and B shift right;
    - carry reg <= `full_adder` cout;
    - counter increments.
  - On the edge where counter == WIDTH-1: capture carry reg (the carry into the MSB) into `c_msb`, then go to DONE.
  - DONE: `out_valid`=1, `sum` = sum register, `cout` = carry reg, `overflow` = `c_msb` ^ carry reg. Go to IDLE on `out_ready`.
- `in_ready` is 1 only in IDLE. In RUN and DONE it is 0, and `in_valid`, `a`, `b`, `cin` are ignored.
- `out_valid` is 1 only in DONE.
- `sum`, `cout` and `overflow` are registered and stable for as long as `out_valid` is high.
- `out_ready` outside DONE has no effect.
- Operands are sampled only on the accepting edge; later changes to `a`/`b` do not affect the result.
- Counter width is $clog2(WIDTH)+1 bits. No wrap occurs within a legal operation.
- WIDTH=1: exactly one RUN cycle; `c_msb` = `cin`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0, all internal registers 0.
- Reset asserted in any state aborts the operation immediately (asynchronous). No `out_valid` is produced for the aborted operation.
- Latency: with the accept edge at T, `out_valid` rises after edge T+WIDTH.
- If `out_ready` is already high, the result transfers at edge T+WIDTH+1. `in_ready` is 1 in the following cycle.
- Minimum initiation interval: WIDTH+2 cycles per operation (accept in IDLE, WIDTH RUN cycles, one DONE cycle).
- Back-pressure: DONE is held indefinitely while `out_ready`=0.
- `in_ready` and `out_valid` are decoded combinationally from the state register only. Neither depends combinationally on `in_valid` or `out_ready`.

## Structure
- `serial_adder_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t`;
  - `localparam` encodings shared by the bench for state checks.
- Sub-module: one existing `full_adder` instance (ports `a`, `b`, `cin`, `sum`, `cout`). No arithmetic beyond it in the datapath.
- Add an elaboration-time assertion for WIDTH in 1..64.

## Test plan
All scenarios use WIDTH=8 unless stated.
1. 8'h35 + 8'h4A, `cin`=0, `out_ready`=1 -> `sum`=8'h7F, `cout`=0, `overflow`=0. `out_valid` rises exactly 8 cycles after the accept edge, high for 1 cycle.
2. 8'hFF + 8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1, `overflow`=0.
3. 8'h7F + 8'h01, `cin`=0 -> `sum`=8'h80, `cout`=0, `overflow`=1. Then 8'h80 + 8'hFF -> `sum`=8'h7F, `cout`=1, `overflow`=1.
4. 8'hFF + 8'hFF, `cin`=1, `out_ready` held 0 for 5 cycles in DONE -> outputs hold `sum`=8'hFF, `cout`=1, `overflow`=0. `in_ready`=0 throughout, and `in_valid` with 8'h11/8'h22 presented meanwhile is ignored. Release `out_ready` -> transfer, then IDLE.
5. Start 8'h0F + 8'h01, assert `rst` in RUN cycle 4 -> `out_valid`=0 and `in_ready`=1 immediately. Next op 8'h01 + 8'h02 -> `sum`=8'h03 with nominal latency.
6. WIDTH=4: exhaustive 16×16×2 operand sweep with random `out_ready` back-pressure and back-to-back `in_valid` -> every result matches a + b + cin, including carry and overflow, with no lost or duplicated transfers. Repeat scenario 1 with WIDTH=1.
